// File: rtl/vec_cmd_issuer.sv
// Host-side command issuer for the vector accelerator: buffers commands in a FIFO, issues
// them one at a time with fields held stable, and returns read vectors under valid/yumi.
module vec_cmd_issuer #(
    parameter int unsigned els_p      = 8,
    parameter int unsigned vlen_p     = 8,
    parameter int unsigned vdw_p      = 8,
    parameter int unsigned fifo_els_p = 4,
    localparam int unsigned AddrW     = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int unsigned DataW     = vlen_p * vdw_p
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_v_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_op_i,
    input  logic [AddrW-1:0]  cmd_addrA_i,
    input  logic [AddrW-1:0]  cmd_addrB_i,
    input  logic [AddrW-1:0]  cmd_addrC_i,
    input  logic [vdw_p-1:0]  cmd_scalar_i,
    input  logic [DataW-1:0]  cmd_data_i,
    output logic              res_v_o,
    output logic [DataW-1:0]  res_data_o,
    input  logic              res_yumi_i,
    output logic              acc_v_o,
    input  logic              acc_ready_i,
    output logic [3:0]        acc_op_o,
    output logic [AddrW-1:0]  acc_addrA_o,
    output logic [AddrW-1:0]  acc_addrB_o,
    output logic [AddrW-1:0]  acc_addrC_o,
    output logic [vdw_p-1:0]  acc_scalar_o,
    output logic [DataW-1:0]  acc_data_o,
    input  logic              acc_done_i,
    input  logic [DataW-1:0]  acc_r_data_i,
    output logic              acc_yumi_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [15:0]       retired_o
);

    localparam int unsigned PtrW = $clog2(fifo_els_p);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(fifo_els_p);
    localparam logic [3:0] OpRead = 4'b1000;

    typedef enum logic [1:0] {StIdle, StWait, StResult} state_e;

    typedef struct packed {
        logic [3:0]       op;
        logic [AddrW-1:0] addr_a;
        logic [AddrW-1:0] addr_b;
        logic [AddrW-1:0] addr_c;
        logic [vdw_p-1:0] scalar;
        logic [DataW-1:0] data;
    } cmd_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b0101, 4'b0110, 4'b1000, 4'b1001: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

    cmd_t            mem_q [fifo_els_p];
    cmd_t            cmd_in;
    cmd_t            head;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    state_e          state_q, state_d;
    logic            err_q, err_d;
    logic [15:0]     retired_q, retired_d;
    logic [DataW-1:0] res_data_q, res_data_d;
    logic            full, empty, push, pop;

    assign cmd_in = {cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i, cmd_scalar_i, cmd_data_i};
    assign head   = mem_q[rd_ptr_q];
    assign full   = (count_q == CountFull);
    assign empty  = (count_q == '0);
    assign push   = cmd_v_i & ~full;

    assign cmd_ready_o  = ~full;
    assign acc_op_o     = head.op;
    assign acc_addrA_o  = head.addr_a;
    assign acc_addrB_o  = head.addr_b;
    assign acc_addrC_o  = head.addr_c;
    assign acc_scalar_o = head.scalar;
    assign acc_data_o   = head.data;
    assign res_data_o   = res_data_q;
    assign err_o        = err_q;
    assign retired_o    = retired_q;
    assign busy_o       = ~empty | (state_q != StIdle);

    // The head is only popped at retirement, so acc_* stay put for the whole operation.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        retired_d  = retired_q;
        res_data_d = res_data_q;
        pop        = 1'b0;
        acc_v_o    = 1'b0;
        acc_yumi_o = 1'b0;
        res_v_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (!op_legal(head.op)) begin
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        acc_v_o = 1'b1;
                        if (acc_ready_i) state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (acc_done_i && !empty) begin
                    pop       = 1'b1;
                    retired_d = retired_q + 16'd1;
                    if (head.op == OpRead) begin
                        acc_yumi_o = 1'b1;
                        res_data_d = acc_r_data_i;
                        state_d    = StResult;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StResult: begin
                res_v_o = 1'b1;
                if (res_yumi_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            err_q      <= 1'b0;
            retired_q  <= '0;
            res_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            err_q      <= err_d;
            retired_q  <= retired_d;
            res_data_q <= res_data_d;
        end
    end

    // Storage needs no reset; the occupancy count guards every read of it.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

endmodule

// File: doc/vec_cmd_issuer.md
# vec_cmd_issuer

Host-side command issuer for the vector accelerator's command/result interface. Buffers host vector commands in a small FIFO and issues them one at a time. Holds every command field stable for the full duration of the operation, since the accelerator samples addresses, op and scalar live. Retires each command on the accelerator's done indication; for read ops it captures the returned vector and presents it to the host under valid/yumi.

## Interface
Parameters:
- els_p, 8, number of vectors in the accelerator register file
- vlen_p, 8, elements per vector
- vdw_p, 8, bits per element
- fifo_els_p, 4, command FIFO depth (power of 2, >= 2)
- Derived: addr_w = clog2(els_p) (safe), data_w = vlen_p*vdw_p

Ports. One clock; reset is synchronous and active-high (clk_i, reset_i).
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cmd_v_i  in  1  host command valid
- cmd_ready_o  out  1  FIFO not full
- cmd_op_i  in  4  opcode
- cmd_addrA_i, cmd_addrB_i, cmd_addrC_i  in  addr_w each  operand A, operand B, destination
- cmd_scalar_i  in  vdw_p  scalar operand
- cmd_data_i  in  data_w  write data (op 1001)
- res_v_o  out  1  read result valid
- res_data_o  out  data_w  read result vector
- res_yumi_i  in  1  host consumes result
- acc_v_o  out  1  command valid to accelerator
- acc_ready_i  in  1  accelerator idle
- acc_op_o  out  4  opcode to accelerator
- acc_addrA_o, acc_addrB_o, acc_addrC_o  out  addr_w each  addresses to accelerator
- acc_scalar_o  out  vdw_p  scalar to accelerator
- acc_data_o  out  data_w  write data to accelerator
- acc_done_i  in  1  accelerator done (1-cycle pulse for non-read ops; held until yumi for read)
- acc_r_data_i  in  data_w  accelerator read data, valid with acc_done_i
- acc_yumi_o  out  1  consume accelerator read result
- err_o  out  1  sticky: illegal opcode dropped
- busy_o  out  1  FIFO non-empty or state != s_IDLE
- retired_o  out  16  count of retired legal commands, wraps

## Operation
- Legal opcodes: 0000, 0001, 0010, 0100, 0101, 0110, 1000 (read), 1001 (write). All others are illegal.
- FIFO:
  - Enqueue on cmd_v_i & cmd_ready_o; cmd_ready_o = !full, with no bypass when full.
  - Enqueue and pop in the same cycle are allowed whenever the FIFO is not full.
  - Pointers wrap modulo fifo_els_p.
- acc_* fields are driven combinationally from the FIFO head at all times. The head is popped only at retirement.
- States:
  - s_IDLE:
    - Head is illegal: pop it, set err_o, do not assert acc_v_o, and do not increment retired_o.
    - Head is legal: acc_v_o=1. On acc_ready_i, go to s_WAIT.
  - s_WAIT: acc_v_o=0. On acc_done_i:
    - Non-read op: pop, increment retired_o, go to s_IDLE.
    - Read op: acc_yumi_o=1 in the same cycle, res_data_o <= acc_r_data_i, pop, increment retired_o, go to s_RESULT.
  - s_RESULT: res_v_o=1. On res_yumi_i, go to s_IDLE. The accelerator stays idle while the result is held.
- acc_yumi_o = (state==s_WAIT) & acc_done_i & head is a read op. Never asserted otherwise.
- err_o clears only on reset.

## Timing
- Reset values:
  - cmd_ready_o=1 (FIFO empty).
  - res_v_o, acc_v_o, acc_yumi_o, err_o, busy_o = 0.
  - res_data_o=0, retired_o=0, state=s_IDLE.
- Enqueue to acc_v_o: 1 cycle minimum (command visible at the head the cycle after enqueue).
- Issue handshake completes in the cycle acc_v_o & acc_ready_i. acc_* fields stay unchanged from that cycle until the retirement cycle inclusive.
- Non-read retire: 1 cycle after acc_done_i the next head may be issued (s_IDLE with acc_v_o=1).
- Read: res_v_o rises the cycle after acc_done_i. res_data_o is stable while res_v_o=1. res_v_o drops the cycle after res_yumi_i.
- Illegal head is dropped in 1 cycle; the next head can issue the cycle after.
- Reset mid-operation, in any state:
  - FIFO is flushed, res_v_o drops, no yumi is issued.
  - The accelerator shares reset_i, so the two blocks return to idle together.

## Test plan
- Write then read:
  - Enqueue op 1001, addrC=3, data=0x0807060504030201.
  - Then enqueue op 1000, addrA=3.
  - Required: res_data_o = 0x0807060504030201, retired_o=2.
- Vector add:
  - Preload v1 = all 0x05 and v2 = all 0x03 via writes.
  - Op 0000 A=1 B=2 C=4, then read v4.
  - Required: all elements 0x08. acc_addr*/acc_op held constant from issue to done.
- FIFO full:
  - Enqueue 5 commands back-to-back with fifo_els_p=4 while the first is executing.
  - Required: cmd_ready_o=0 after the 4th; the 5th is accepted after the first retire; in-order completion.
- Result backpressure:
  - Read with res_yumi_i held low for 10 cycles.
  - Required: res_v_o=1 and data stable throughout; the next queued command is not issued until 1 cycle after yumi.
- Illegal op:
  - Enqueue op 0011 followed by a legal write.
  - Required: err_o=1 and sticky, no acc_v_o for 0011, the write executes, retired_o=1.
- Reset mid-op:
  - Assert reset_i in s_WAIT with 2 commands queued.
  - Required: all outputs at reset values next cycle, busy_o=0, queued commands never issued.
